// File: rtl/timer_ctrl_seq_pkg.sv
// timer_ctrl_seq_pkg: timer register map, control bits, command encoding and sequencer states.
package timer_ctrl_seq_pkg;
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CTRL     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
    localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
    localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;
    typedef enum logic [1:0] {OP_START, OP_STOP, OP_SNAPSHOT, OP_NOP} op_e;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_SNAP_WR, S_SNAP_RD_L,
        S_SNAP_RD_H, S_SNAP_CAP, S_IRQ_CLR, S_IRQ_WAIT, S_DONE
    } state_e;
    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        ctrl_word = '0;
        ctrl_word[CTRL_STOP_BIT]  = stop;
        ctrl_word[CTRL_START_BIT] = start;
        ctrl_word[CTRL_CONT_BIT]  = cont;
        ctrl_word[CTRL_ITO_BIT]   = ito;
    endfunction
endpackage

// File: rtl/timer_ctrl_seq_tick_cnt.sv
// timer_ctrl_seq_tick_cnt: saturating serviced-timeout counter, cleared on START.
// Only compiled when TIMER_CTRL_SEQ_TICK_CNT_EN is defined.
`ifdef TIMER_CTRL_SEQ_TICK_CNT_EN
module timer_ctrl_seq_tick_cnt
    import timer_ctrl_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && r_count != '1)
            r_count <= r_count + 1'b1;
    assign o_count = r_count;
endmodule
`endif

// File: rtl/timer_ctrl_seq.sv
// timer_ctrl_seq: turns host START/STOP/SNAPSHOT commands into timer slave bus cycles and services timer irqs.
// Define TIMER_CTRL_SEQ_TICK_CNT_EN to enable the saturating tick_count; otherwise tick_count is 0.
module timer_ctrl_seq
    import timer_ctrl_seq_pkg::*;
#(
    parameter int   TICK_W   = 16,
    parameter logic CTRL_ITO = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [2:0]        tmr_address,
    output logic              tmr_chipselect,
    output logic              tmr_write_n,
    output logic [15:0]       tmr_writedata,
    input  logic [15:0]       tmr_readdata,
    input  logic              tmr_irq
);
    state_e      r_state, w_state_nxt;
    op_e         r_op;
    logic [31:0] r_period, r_rsp_data;
    logic [15:0] r_snap_lo;
    logic        r_cont;
    logic        w_accept;

    assign cmd_ready = reset_n && r_state == S_IDLE && !tmr_irq;
    assign w_accept  = cmd_valid && cmd_ready;
    assign rsp_valid = r_state == S_DONE;
    assign tick      = r_state == S_IRQ_CLR;
    assign rsp_data  = r_rsp_data;

    always_comb begin
        w_state_nxt    = r_state;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = ADDR_STATUS;
        tmr_writedata  = '0;
        case (r_state)
            S_IDLE:
                w_state_nxt = tmr_irq ? S_IRQ_CLR :
                              !cmd_valid ? S_IDLE :
                              op_e'(cmd_op) == OP_START ? S_WR_PL :
                              op_e'(cmd_op) == OP_STOP ? S_WR_CTRL :
                              op_e'(cmd_op) == OP_SNAPSHOT ? S_SNAP_WR : S_DONE;
            S_WR_PL: begin
                w_state_nxt = S_WR_PH;
                {tmr_chipselect, tmr_write_n, tmr_address} = {2'b10, ADDR_PERIOD_L};
                tmr_writedata = r_period[15:0];
            end
            S_WR_PH: begin
                w_state_nxt = S_WR_CTRL;
                {tmr_chipselect, tmr_write_n, tmr_address} = {2'b10, ADDR_PERIOD_H};
                tmr_writedata = r_period[31:16];
            end
            S_WR_CTRL: begin
                w_state_nxt = S_DONE;
                {tmr_chipselect, tmr_write_n, tmr_address} = {2'b10, ADDR_CTRL};
                tmr_writedata = r_op == OP_START ? ctrl_word(1'b0, 1'b1, r_cont, CTRL_ITO)
                                                 : ctrl_word(1'b1, 1'b0, 1'b0, CTRL_ITO);
            end
            S_SNAP_WR: begin
                w_state_nxt = S_SNAP_RD_L;
                {tmr_chipselect, tmr_write_n, tmr_address} = {2'b10, ADDR_SNAP_L};
            end
            S_SNAP_RD_L: begin
                w_state_nxt = S_SNAP_RD_H;
                {tmr_chipselect, tmr_address} = {1'b1, ADDR_SNAP_L};
            end
            S_SNAP_RD_H: begin
                w_state_nxt = S_SNAP_CAP;
                {tmr_chipselect, tmr_address} = {1'b1, ADDR_SNAP_H};
            end
            S_SNAP_CAP: w_state_nxt = S_DONE;
            S_IRQ_CLR: begin
                w_state_nxt = S_IRQ_WAIT;
                {tmr_chipselect, tmr_write_n, tmr_address} = {2'b10, ADDR_STATUS};
            end
            S_IRQ_WAIT: w_state_nxt = S_IDLE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read data trails the address by one cycle, so each half is captured in the state after its read.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_period   <= '0;
            r_cont     <= 1'b0;
            r_snap_lo  <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op     <= op_e'(cmd_op);
                r_period <= cmd_period;
                r_cont   <= cmd_continuous;
            end
            if (r_state == S_SNAP_RD_H)
                r_snap_lo <= tmr_readdata;
            if (r_state == S_SNAP_CAP)
                r_rsp_data <= {tmr_readdata, r_snap_lo};
            else if (w_state_nxt == S_DONE)
                r_rsp_data <= '0;
        end

`ifdef TIMER_CTRL_SEQ_TICK_CNT_EN
    timer_ctrl_seq_tick_cnt #(.W(TICK_W)) u_tick_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_accept && op_e'(cmd_op) == OP_START),
        .i_inc   (tick),
        .o_count (tick_count)
    );
`else
    assign tick_count = '0;
`endif
endmodule

// File: tb/tb_timer_ctrl_seq.sv
// tb_timer_ctrl_seq: scoreboard bench for timer_ctrl_seq with a small timer slave model.
module tb_timer_ctrl_seq;
    localparam int TW = 8;
`ifdef TIMER_CTRL_SEQ_TICK_CNT_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif
    logic          clk = 1'b0, reset_n = 1'b0, cmd_valid = 1'b0, cmd_continuous = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [31:0]   cmd_period = 32'h0;
    logic          cmd_ready, rsp_valid, tick, tmr_chipselect, tmr_write_n;
    logic          tmr_irq = 1'b0;
    logic [31:0]   rsp_data;
    logic [TW-1:0] tick_count;
    logic [2:0]    tmr_address;
    logic [15:0]   tmr_writedata;
    logic [15:0]   tmr_readdata = 16'h0;
    logic [31:0]   snap_val = 32'h1234_5678;
    int n_cmp = 0, n_err = 0, cyc = 0, irq_req = 0, irq_ack = 0, ticks = 0, tc_model = 0;
    logic [18:0] exp_wr[$];
    logic [31:0] exp_rsp_d[$];
    int          exp_rsp_l[$];
    int          acc_q[$];

    timer_ctrl_seq #(.TICK_W(TW), .CTRL_ITO(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .tick(tick), .tick_count(tick_count),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer model: registered read data, irq set on request and cleared by a status write.
    always @(posedge clk) begin
        if (irq_req != irq_ack) begin
            tmr_irq <= 1'b1;
            irq_ack <= irq_ack + 1;
        end else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0)
            tmr_irq <= 1'b0;
        tmr_readdata <= tmr_address == 3'd4 ? snap_val[15:0] :
                        tmr_address == 3'd5 ? snap_val[31:16] : 16'h0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s", nm);
    endtask

    always @(negedge clk) begin
        if (!reset_n)
            acc_q.delete();
        else begin
            if (cmd_valid && cmd_ready)
                acc_q.push_back(cyc);
            if (tmr_chipselect && !tmr_write_n) begin
                if (exp_wr.size() == 0)
                    miss($sformatf("unexpected_write addr=%0d data=0x%0h (none required)", tmr_address, tmr_writedata));
                else
                    chk("bus_write", 64'({tmr_address, tmr_writedata}), 64'(exp_wr.pop_front()));
            end
            if (rsp_valid) begin
                if (exp_rsp_d.size() == 0 || acc_q.size() == 0)
                    miss($sformatf("unexpected_rsp data=0x%0h (none required)", rsp_data));
                else begin
                    chk("rsp_data", 64'(rsp_data), 64'(exp_rsp_d.pop_front()));
                    chk("rsp_latency", 64'(cyc - acc_q.pop_front()), 64'(exp_rsp_l.pop_front()));
                end
            end
            if (tick) begin
                ticks++;
                chk("tick_with_status_clear", 64'({tmr_chipselect, tmr_write_n, tmr_address}), 64'(5'b10_000));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] per, input logic cont,
                         input logic [31:0] exp_d, input int exp_l);
        bit acc = 1'b0;
        exp_rsp_d.push_back(exp_d);
        exp_rsp_l.push_back(exp_l);
        cmd_valid = 1'b1; cmd_op = op; cmd_period = per; cmd_continuous = cont;
        for (int n = 0; n < 40 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #2;
        end
        cmd_valid = 1'b0; cmd_op = 2'd3; cmd_period = 32'hDEAD_BEEF; cmd_continuous = ~cont;
        if (!acc) miss($sformatf("accept_timeout op=%0d", op));
        if (acc && op == 2'd0) tc_model = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rsp_d.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) miss($sformatf("drain_timeout writes_left=%0d rsps_left=%0d", exp_wr.size(), exp_rsp_d.size()));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic fire_irq();
        irq_req++;
        exp_wr.push_back({3'd0, 16'h0});
        if (tc_model < 255) tc_model++;
    endtask

    task automatic chk_outputs_idle(input string nm);
        chk({nm, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({nm, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({nm, "_tick"}, 64'(tick), 64'(0));
        chk({nm, "_tick_count"}, 64'(tick_count), 64'(0));
        chk({nm, "_bus"}, 64'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}), 64'({2'b01, 19'h0}));
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_idle("reset");
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #2;
        // START with continuous mode, period split across two writes
        exp_wr.push_back({3'd2, 16'h86A0}); exp_wr.push_back({3'd3, 16'h0001}); exp_wr.push_back({3'd1, 16'h0007});
        issue(2'd0, 32'h0001_86A0, 1'b1, 32'h0, 4);
        drain();
        exp_wr.push_back({3'd1, 16'h0009});
        issue(2'd1, 32'h5A5A_5A5A, 1'b1, 32'h0, 2);
        drain();
        exp_wr.push_back({3'd2, 16'h0123}); exp_wr.push_back({3'd3, 16'hABCD}); exp_wr.push_back({3'd1, 16'h0005});
        issue(2'd0, 32'hABCD_0123, 1'b0, 32'h0, 4);
        drain();
        exp_wr.push_back({3'd4, 16'h0});
        issue(2'd2, 32'h0, 1'b0, 32'h1234_5678, 5);
        drain();
        snap_val = 32'hFEDC_0BA9;
        exp_wr.push_back({3'd4, 16'h0});
        issue(2'd2, 32'h0, 1'b1, 32'hFEDC_0BA9, 5);
        drain();
        issue(2'd3, 32'h1111_2222, 1'b0, 32'h0, 1);
        drain();
        // irq pending in IDLE beats a waiting command
        t0 = ticks;
        fire_irq();
        exp_wr.push_back({3'd1, 16'h0009});
        @(posedge clk); #2;
        cmd_valid = 1'b1; cmd_op = 2'd1;
        @(negedge clk);
        chk("irq_blocks_ready", 64'(cmd_ready), 64'(0));
        issue(2'd1, 32'h0, 1'b0, 32'h0, 2);
        drain();
        chk("irq_idle_ticks", 64'(ticks - t0), 64'(1));
        // irq during START is deferred until the sequence finishes
        t0 = ticks;
        exp_wr.push_back({3'd2, 16'h0010}); exp_wr.push_back({3'd3, 16'h0020}); exp_wr.push_back({3'd1, 16'h0007});
        issue(2'd0, 32'h0020_0010, 1'b1, 32'h0, 4);
        fire_irq();
        drain();
        chk("irq_deferred_ticks", 64'(ticks - t0), 64'(1));
        chk("tick_count_after_one", 64'(tick_count), 64'(TC_EN ? tc_model : 0));
        for (int i = 0; i < 300; i++) begin
            int t = ticks;
            fire_irq();
            for (int n = 0; n < 10 && ticks == t; n++) @(posedge clk);
            repeat (3) @(posedge clk); #2;
            if (i == 99) chk("tick_count_mid", 64'(tick_count), 64'(TC_EN ? tc_model : 0));
        end
        drain();
        chk("tick_count_saturated", 64'(tick_count), 64'(TC_EN ? tc_model : 0));
        chk("tick_count_expect_255", 64'(tc_model), 64'(255));
        exp_wr.push_back({3'd2, 16'h0001}); exp_wr.push_back({3'd3, 16'h0000}); exp_wr.push_back({3'd1, 16'h0005});
        issue(2'd0, 32'h0000_0001, 1'b0, 32'h0, 4);
        drain();
        chk("tick_count_cleared", 64'(tick_count), 64'(0));
        // reset while writing period_h: nothing after the period_l write
        exp_wr.push_back({3'd2, 16'h5555});
        issue(2'd0, 32'hAAAA_5555, 1'b1, 32'h0, 4);
        @(posedge clk); #2;
        reset_n = 1'b0;
        @(negedge clk);
        chk_outputs_idle("abort");
        exp_rsp_d.delete(); exp_rsp_l.delete();
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk); #2;
        chk("abort_no_pending_write", 64'(exp_wr.size()), 64'(0));
        exp_wr.push_back({3'd2, 16'h4321}); exp_wr.push_back({3'd3, 16'h8765}); exp_wr.push_back({3'd1, 16'h0007});
        issue(2'd0, 32'h8765_4321, 1'b1, 32'h0, 4);
        drain();
        chk("final_pending_writes", 64'(exp_wr.size()), 64'(0));
        chk("final_pending_rsps", 64'(exp_rsp_d.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
